// File: rtl/rx_fifo_rd_arbiter_pkg.sv
// Shared types and constants for the RX FIFO read arbiter.
package rx_fifo_rd_arbiter_pkg;

  localparam int unsigned MaxLenDefault = 64;
  localparam int unsigned LenW          = 7;

  typedef enum logic [1:0] {
    StIdle,
    StBurst,
    StDone
  } state_e;

  // Saturate a requested length to the configured maximum burst size.
  function automatic logic [LenW-1:0] clamp_len(input logic [LenW-1:0] len,
                                                input int unsigned     max_len);
    if (32'(len) > max_len) begin
      return LenW'(max_len);
    end
    return len;
  endfunction

endpackage

// File: rtl/rx_fifo_rd_arbiter_rr_arbiter2.sv
// Combinational two-way round-robin pick: on contention the requester not
// granted last time wins.
module rr_arbiter2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] gnt_o,
  output logic       idx_o
);

  always_comb begin
    idx_o = 1'b0;
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   idx_o = 1'b0;
      2'b10:   idx_o = 1'b1;
      2'b11:   idx_o = ~last_i;
      default: idx_o = 1'b0;
    endcase
    if (req_i != 2'b00) begin
      gnt_o = idx_o ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/rx_fifo_rd_arbiter.sv
// Grants one of two requesters a length-bounded burst of pops from a shared
// RX FIFO, returning the popped bytes one cycle after each pop.
module rx_fifo_rd_arbiter
  import rx_fifo_rd_arbiter_pkg::*;
#(
  parameter int unsigned MAX_LEN = MaxLenDefault
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      req,
  input  logic [LenW-1:0] req_len0,
  input  logic [LenW-1:0] req_len1,
  input  logic            fifo_empty,
  input  logic [7:0]      fifo_r_data,
  output logic            fifo_r_enable,
  output logic [1:0]      gnt,
  output logic            rd_valid,
  output logic [7:0]      rd_data,
  output logic            burst_done,
  output logic            burst_abort
);

  state_e          state_q, state_d;
  logic [LenW-1:0] rem_q, rem_d;
  logic            owner_q, owner_d;
  logic            last_q, last_d;
  logic [1:0]      gnt_q, gnt_d;
  logic            rd_valid_q, rd_valid_d;
  logic [7:0]      rd_data_q, rd_data_d;
  logic            done_q, done_d;
  logic            abort_q, abort_d;

  logic [1:0]      pick_gnt;
  logic            pick_idx;
  logic            pop;

  rr_arbiter2 u_rr (
    .req_i  (req),
    .last_i (last_q),
    .gnt_o  (pick_gnt),
    .idx_o  (pick_idx)
  );

  // Reset gates the pop so a mid-burst reset never steals a FIFO byte.
  assign pop = (state_q == StBurst) && !fifo_empty && (rem_q != '0) && req[owner_q] && !rst;

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    owner_d    = owner_q;
    last_d     = last_q;
    gnt_d      = gnt_q;
    rd_valid_d = pop;
    rd_data_d  = pop ? fifo_r_data : rd_data_q;
    done_d     = 1'b0;
    abort_d    = 1'b0;
    case (state_q)
      StIdle: begin
        if (req != 2'b00) begin
          owner_d = pick_idx;
          gnt_d   = pick_gnt;
          rem_d   = clamp_len(pick_idx ? req_len1 : req_len0, MAX_LEN);
          state_d = StBurst;
        end
      end
      StBurst: begin
        if (!req[owner_q]) begin
          state_d = StDone;
          gnt_d   = 2'b00;
          done_d  = 1'b1;
          abort_d = (rem_q != '0);
        end else if (rem_q == '0) begin
          state_d = StDone;
          gnt_d   = 2'b00;
          done_d  = 1'b1;
        end else if (pop) begin
          rem_d = rem_q - LenW'(1);
          if (rem_q == LenW'(1)) begin
            state_d = StDone;
            gnt_d   = 2'b00;
            done_d  = 1'b1;
          end
        end
      end
      StDone: begin
        last_d  = owner_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      rem_q      <= '0;
      owner_q    <= 1'b0;
      last_q     <= 1'b1;
      gnt_q      <= 2'b00;
      rd_valid_q <= 1'b0;
      rd_data_q  <= 8'h00;
      done_q     <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      gnt_q      <= gnt_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      done_q     <= done_d;
      abort_q    <= abort_d;
    end
  end

  assign fifo_r_enable = pop;
  assign gnt           = gnt_q;
  assign rd_valid      = rd_valid_q;
  assign rd_data       = rd_data_q;
  assign burst_done    = done_q;
  assign burst_abort   = abort_q;

endmodule

// File: tb/tb_rx_fifo_rd_arbiter.sv
// Directed, table-driven bench for rx_fifo_rd_arbiter with a small FIFO model.
module tb_rx_fifo_rd_arbiter;

  localparam int unsigned MaxLen = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req;
  logic [6:0] req_len0, req_len1;
  logic       fifo_empty;
  logic [7:0] fifo_r_data;
  logic       fifo_r_enable;
  logic [1:0] gnt;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       burst_done;
  logic       burst_abort;

  rx_fifo_rd_arbiter #(.MAX_LEN(MaxLen)) dut (
    .clk           (clk),
    .rst           (rst),
    .req           (req),
    .req_len0      (req_len0),
    .req_len1      (req_len1),
    .fifo_empty    (fifo_empty),
    .fifo_r_data   (fifo_r_data),
    .fifo_r_enable (fifo_r_enable),
    .gnt           (gnt),
    .rd_valid      (rd_valid),
    .rd_data       (rd_data),
    .burst_done    (burst_done),
    .burst_abort   (burst_abort)
  );

  always #5 clk = ~clk;

  // FIFO model: preloaded array, popped on the DUT's strobe.
  logic [7:0] mem [64];
  int         wr_ptr = 0;
  int         rd_ptr = 0;
  logic       force_empty;

  assign fifo_empty  = (wr_ptr == rd_ptr) || force_empty;
  assign fifo_r_data = mem[rd_ptr[5:0]];

  always @(posedge clk) begin
    if (fifo_r_enable) rd_ptr <= rd_ptr + 1;
  end

  typedef struct {
    logic       rst;
    logic [1:0] req;
    logic [6:0] len0;
    logic [6:0] len1;
    logic       empty;
    logic [1:0] gnt;
    logic       en;
    logic       vld;
    logic [7:0] data;
    logic       done;
    logic       abort;
  } vec_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   step_no  = 0;
  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic [1:0] rq, logic [6:0] l0, logic [6:0] l1,
                              logic e, logic [1:0] g, logic en, logic vl, logic [7:0] d,
                              logic dn, logic ab);
    vec_t v;
    v.rst = r; v.req = rq; v.len0 = l0; v.len1 = l1; v.empty = e;
    v.gnt = g; v.en = en; v.vld = vl; v.data = d; v.done = dn; v.abort = ab;
    return v;
  endfunction

  task automatic push(input logic [7:0] b);
    mem[wr_ptr[5:0]] = b;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic chk(input string what, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL step %0d %s: got %h, expected %h", step_no, what, act, exp);
    end
  endtask

  // Drive on the falling edge, compare 1 ns later, then advance one cycle.
  task automatic step(input vec_t v);
    rst         = v.rst;
    req         = v.req;
    req_len0    = v.len0;
    req_len1    = v.len1;
    force_empty = v.empty;
    #1;
    chk("gnt", {6'b0, gnt}, {6'b0, v.gnt});
    chk("fifo_r_enable", {7'b0, fifo_r_enable}, {7'b0, v.en});
    chk("rd_valid", {7'b0, rd_valid}, {7'b0, v.vld});
    chk("rd_data", rd_data, v.data);
    chk("burst_done", {7'b0, burst_done}, {7'b0, v.done});
    chk("burst_abort", {7'b0, burst_abort}, {7'b0, v.abort});
    step_no++;
    @(negedge clk);
  endtask

  logic [7:0] clamp_seq [8];

  initial begin
    rst = 1'b1; req = 2'b00; req_len0 = '0; req_len1 = '0; force_empty = 1'b0;
    for (int i = 1; i <= 4; i++) push(8'hA0 + 8'(i));
    for (int i = 1; i <= 6; i++) push(8'hB0 + 8'(i));
    for (int i = 1; i <= 3; i++) push(8'hC0 + 8'(i));
    for (int i = 1; i <= 6; i++) push(8'hD0 + 8'(i));
    for (int i = 1; i <= 8; i++) push(8'hE0 + 8'(i));

    // Single burst of 4 from requester 0, then zero-length burst for requester 1,
    // then three contended bursts alternating 0,1,0.
    tbl.push_back(mk(0, 2'b00, 0, 0, 0, 2'b00, 0, 0, 8'h00, 0, 0));
    tbl.push_back(mk(0, 2'b01, 4, 0, 0, 2'b00, 0, 0, 8'h00, 0, 0));
    tbl.push_back(mk(0, 2'b01, 4, 0, 0, 2'b01, 1, 0, 8'h00, 0, 0));
    tbl.push_back(mk(0, 2'b01, 4, 0, 0, 2'b01, 1, 1, 8'hA1, 0, 0));
    tbl.push_back(mk(0, 2'b01, 4, 0, 0, 2'b01, 1, 1, 8'hA2, 0, 0));
    tbl.push_back(mk(0, 2'b01, 4, 0, 0, 2'b01, 1, 1, 8'hA3, 0, 0));
    tbl.push_back(mk(0, 2'b00, 4, 0, 0, 2'b00, 0, 1, 8'hA4, 1, 0));
    tbl.push_back(mk(0, 2'b00, 4, 0, 0, 2'b00, 0, 0, 8'hA4, 0, 0));
    tbl.push_back(mk(0, 2'b10, 0, 0, 0, 2'b00, 0, 0, 8'hA4, 0, 0));
    tbl.push_back(mk(0, 2'b10, 0, 0, 0, 2'b10, 0, 0, 8'hA4, 0, 0));
    tbl.push_back(mk(0, 2'b00, 0, 0, 0, 2'b00, 0, 0, 8'hA4, 1, 0));
    tbl.push_back(mk(0, 2'b00, 0, 0, 0, 2'b00, 0, 0, 8'hA4, 0, 0));
    tbl.push_back(mk(0, 2'b11, 2, 2, 0, 2'b00, 0, 0, 8'hA4, 0, 0));
    tbl.push_back(mk(0, 2'b11, 2, 2, 0, 2'b01, 1, 0, 8'hA4, 0, 0));
    tbl.push_back(mk(0, 2'b11, 2, 2, 0, 2'b01, 1, 1, 8'hB1, 0, 0));
    tbl.push_back(mk(0, 2'b11, 2, 2, 0, 2'b00, 0, 1, 8'hB2, 1, 0));
    tbl.push_back(mk(0, 2'b11, 2, 2, 0, 2'b00, 0, 0, 8'hB2, 0, 0));
    tbl.push_back(mk(0, 2'b11, 2, 2, 0, 2'b10, 1, 0, 8'hB2, 0, 0));
    tbl.push_back(mk(0, 2'b11, 2, 2, 0, 2'b10, 1, 1, 8'hB3, 0, 0));
    tbl.push_back(mk(0, 2'b11, 2, 2, 0, 2'b00, 0, 1, 8'hB4, 1, 0));
    tbl.push_back(mk(0, 2'b11, 2, 2, 0, 2'b00, 0, 0, 8'hB4, 0, 0));
    tbl.push_back(mk(0, 2'b11, 2, 2, 0, 2'b01, 1, 0, 8'hB4, 0, 0));
    tbl.push_back(mk(0, 2'b11, 2, 2, 0, 2'b01, 1, 1, 8'hB5, 0, 0));
    tbl.push_back(mk(0, 2'b00, 2, 2, 0, 2'b00, 0, 1, 8'hB6, 1, 0));
    tbl.push_back(mk(0, 2'b00, 2, 2, 0, 2'b00, 0, 0, 8'hB6, 0, 0));

    repeat (2) @(posedge clk);
    @(negedge clk);
    foreach (tbl[i]) step(tbl[i]);

    // Stall: FIFO empty for 5 cycles after the first pop, counter must hold.
    step(mk(0, 2'b01, 3, 0, 0, 2'b00, 0, 0, 8'hB6, 0, 0));
    step(mk(0, 2'b01, 3, 0, 0, 2'b01, 1, 0, 8'hB6, 0, 0));
    step(mk(0, 2'b01, 3, 0, 1, 2'b01, 0, 1, 8'hC1, 0, 0));
    for (int i = 0; i < 4; i++) step(mk(0, 2'b01, 3, 0, 1, 2'b01, 0, 0, 8'hC1, 0, 0));
    step(mk(0, 2'b01, 3, 0, 0, 2'b01, 1, 0, 8'hC1, 0, 0));
    step(mk(0, 2'b01, 3, 0, 0, 2'b01, 1, 1, 8'hC2, 0, 0));
    step(mk(0, 2'b00, 3, 0, 0, 2'b00, 0, 1, 8'hC3, 1, 0));
    step(mk(0, 2'b00, 3, 0, 0, 2'b00, 0, 0, 8'hC3, 0, 0));

    // Abort: requester 0 drops after 2 of 6 pops.
    step(mk(0, 2'b01, 6, 0, 0, 2'b00, 0, 0, 8'hC3, 0, 0));
    step(mk(0, 2'b01, 6, 0, 0, 2'b01, 1, 0, 8'hC3, 0, 0));
    step(mk(0, 2'b01, 6, 0, 0, 2'b01, 1, 1, 8'hD1, 0, 0));
    step(mk(0, 2'b00, 6, 0, 0, 2'b01, 0, 1, 8'hD2, 0, 0));
    step(mk(0, 2'b00, 6, 0, 0, 2'b00, 0, 0, 8'hD2, 1, 1));
    step(mk(0, 2'b00, 6, 0, 0, 2'b00, 0, 0, 8'hD2, 0, 0));

    // Reset mid-burst: pop drops at once, then contention goes to requester 0.
    step(mk(0, 2'b01, 6, 0, 0, 2'b00, 0, 0, 8'hD2, 0, 0));
    step(mk(0, 2'b01, 6, 0, 0, 2'b01, 1, 0, 8'hD2, 0, 0));
    step(mk(1, 2'b01, 6, 0, 0, 2'b01, 0, 1, 8'hD3, 0, 0));
    step(mk(0, 2'b11, 0, 0, 0, 2'b00, 0, 0, 8'h00, 0, 0));
    step(mk(0, 2'b11, 0, 0, 0, 2'b01, 0, 0, 8'h00, 0, 0));
    step(mk(0, 2'b00, 0, 0, 0, 2'b00, 0, 0, 8'h00, 1, 0));
    step(mk(0, 2'b00, 0, 0, 0, 2'b00, 0, 0, 8'h00, 0, 0));

    // Oversized length is clamped to MaxLen pops.
    clamp_seq = '{8'hD4, 8'hD5, 8'hD6, 8'hE1, 8'hE2, 8'hE3, 8'hE4, 8'hE5};
    step(mk(0, 2'b10, 0, 127, 0, 2'b00, 0, 0, 8'h00, 0, 0));
    step(mk(0, 2'b10, 0, 127, 0, 2'b10, 1, 0, 8'h00, 0, 0));
    for (int i = 0; i < 7; i++) step(mk(0, 2'b10, 0, 127, 0, 2'b10, 1, 1, clamp_seq[i], 0, 0));
    step(mk(0, 2'b00, 0, 127, 0, 2'b00, 0, 1, clamp_seq[7], 1, 0));
    step(mk(0, 2'b00, 0, 127, 0, 2'b00, 0, 0, clamp_seq[7], 0, 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
